// File: rtl/branch_update_queue_if.sv
// Branch update queue bus: fetch push, ID resolve,
// predictor update and front-end redirect.
interface branch_update_queue_if #(
  parameter int PTR_W = 3
);
  logic             push_valid;
  logic             push_ready;
  logic [31:0]      push_pc;
  logic             push_hit;
  logic             push_dir;
  logic [31:0]      push_tar;
  logic [1:0]       push_type;
  logic             res_valid;
  logic             res_dir;
  logic [31:0]      res_tar;
  logic [1:0]       res_type;
  logic             upd_valid;
  logic             upd_pred_ok;
  logic [21:0]      upd_tag;
  logic [7:0]       upd_index;
  logic             upd_dir;
  logic [31:0]      upd_tar;
  logic [1:0]       upd_type;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [PTR_W:0]   count;

  modport master (
    output push_valid, push_pc, push_hit,
    output push_dir, push_tar, push_type,
    output res_valid, res_dir, res_tar, res_type,
    input  push_ready, upd_valid, upd_pred_ok,
    input  upd_tag, upd_index, upd_dir,
    input  upd_tar, upd_type,
    input  redirect_valid, redirect_pc, count
  );

  modport slave (
    input  push_valid, push_pc, push_hit,
    input  push_dir, push_tar, push_type,
    input  res_valid, res_dir, res_tar, res_type,
    output push_ready, upd_valid, upd_pred_ok,
    output upd_tag, upd_index, upd_dir,
    output upd_tar, upd_type,
    output redirect_valid, redirect_pc, count
  );
endinterface

// File: rtl/branch_update_queue.sv
// In-flight branch prediction FIFO; compares predictions
// with ID resolution and emits predictor updates/redirects.
module branch_update_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input logic clk,
  input logic resetn,
  branch_update_queue_if.slave bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic        hit;
    logic        dir;
    logic [31:0] tar;
    logic [1:0]  typ;
  } entry_t;

  localparam logic [PTR_W:0] CNT_FULL =
    (PTR_W+1)'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push_acc;
  logic             res_acc;
  logic             misp;
  logic [31:0]      rpc;
  entry_t           hd;

  logic             upd_valid;
  logic             upd_pred_ok;
  logic [21:0]      upd_tag;
  logic [7:0]       upd_index;
  logic             upd_dir;
  logic [31:0]      upd_tar;
  logic [1:0]       upd_type;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign hd    = mem[head];

  assign bus.push_ready = !full && !redirect_valid;
  assign push_acc = bus.push_valid && bus.push_ready;
  assign res_acc  = bus.res_valid && !empty;

  always_comb begin
    misp = 1'b0;
    rpc  = '0;
    misp = (hd.dir != bus.res_dir)
        || (bus.res_dir &&
            (!hd.hit || hd.tar != bus.res_tar))
        || (hd.hit && hd.typ != bus.res_type);
    // not-taken restart skips the delay slot
    rpc  = bus.res_dir ? bus.res_tar
                       : hd.pc + 32'd8;
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[tail] <= '{
        pc:  bus.push_pc,
        hit: bus.push_hit,
        dir: bus.push_dir,
        tar: bus.push_tar,
        typ: bus.push_type
      };
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      upd_valid      <= 1'b0;
      upd_pred_ok    <= 1'b0;
      upd_tag        <= '0;
      upd_index      <= '0;
      upd_dir        <= 1'b0;
      upd_tar        <= '0;
      upd_type       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      if (res_acc && misp) begin
        // flush younger entries and the wrong-path push
        head  <= head + 1'b1;
        tail  <= head + 1'b1;
        count <= '0;
      end else begin
        if (push_acc) tail <= tail + 1'b1;
        if (res_acc)  head <= head + 1'b1;
        count <= count
               + (PTR_W+1)'(push_acc)
               - (PTR_W+1)'(res_acc);
      end
      upd_valid      <= res_acc;
      upd_pred_ok    <= res_acc && !misp;
      upd_tag        <= res_acc ? hd.pc[31:10] : '0;
      upd_index      <= res_acc ? hd.pc[9:2] : '0;
      upd_dir        <= res_acc && bus.res_dir;
      upd_tar        <= res_acc ? bus.res_tar : '0;
      upd_type       <= res_acc ? bus.res_type : '0;
      redirect_valid <= res_acc && misp;
      redirect_pc    <= (res_acc && misp) ? rpc : '0;
    end
  end

  assign bus.count          = count;
  assign bus.upd_valid      = upd_valid;
  assign bus.upd_pred_ok    = upd_pred_ok;
  assign bus.upd_tag        = upd_tag;
  assign bus.upd_index      = upd_index;
  assign bus.upd_dir        = upd_dir;
  assign bus.upd_tar        = upd_tar;
  assign bus.upd_type       = upd_type;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue: vector table
// plus full/wrap, flush, empty-resolve and reset sequences.
module tb_branch_update_queue;

  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  branch_update_queue_if #(.PTR_W(3)) bus ();

  branch_update_queue #(
    .DEPTH(8),
    .PTR_W(3)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic        dir;
    logic [31:0] tar;
    logic [1:0]  typ;
    logic        rdir;
    logic [31:0] rtar;
    logic [1:0]  rtyp;
    logic        ok;
    logic [31:0] rpc;
    logic [21:0] tag;
    logic [7:0]  idx;
  } vec_t;

  vec_t vt [7];
  logic [31:0] model [$];
  logic [31:0] exp_pc;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.push_valid = 1'b0;
    bus.push_pc    = '0;
    bus.push_hit   = 1'b0;
    bus.push_dir   = 1'b0;
    bus.push_tar   = '0;
    bus.push_type  = '0;
    bus.res_valid  = 1'b0;
    bus.res_dir    = 1'b0;
    bus.res_tar    = '0;
    bus.res_type   = '0;
  endtask

  task automatic set_push(input logic [31:0] pc,
                          input logic hit,
                          input logic dir,
                          input logic [31:0] tar,
                          input logic [1:0] typ);
    bus.push_valid = 1'b1;
    bus.push_pc    = pc;
    bus.push_hit   = hit;
    bus.push_dir   = dir;
    bus.push_tar   = tar;
    bus.push_type  = typ;
  endtask

  task automatic set_res(input logic dir,
                         input logic [31:0] tar,
                         input logic [1:0] typ);
    bus.res_valid = 1'b1;
    bus.res_dir   = dir;
    bus.res_tar   = tar;
    bus.res_type  = typ;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
  endtask

  initial begin
    vt[0] = '{32'hBFC0_0100, 1, 1, 32'hBFC0_0200, 2'd1,
              1, 32'hBFC0_0200, 2'd1,
              1, 32'h0, 22'h2FF000, 8'h40};
    vt[1] = '{32'h8000_0010, 1, 1, 32'h8000_0100, 2'd0,
              0, 32'h0, 2'd0,
              0, 32'h8000_0018, 22'h200000, 8'h04};
    vt[2] = '{32'h0000_1234, 0, 0, 32'h0, 2'd0,
              0, 32'hDEAD_0000, 2'd2,
              1, 32'h0, 22'h000004, 8'h8D};
    vt[3] = '{32'h0040_0000, 0, 1, 32'h0040_0040, 2'd1,
              1, 32'h0040_0040, 2'd1,
              0, 32'h0040_0040, 22'h001000, 8'h00};
    vt[4] = '{32'h1000_0FFC, 1, 1, 32'h1000_2000, 2'd1,
              1, 32'h1000_3000, 2'd1,
              0, 32'h1000_3000, 22'h040003, 8'hFF};
    vt[5] = '{32'hFFFF_FFFC, 1, 0, 32'h0, 2'd2,
              0, 32'h0, 2'd3,
              0, 32'h0000_0004, 22'h3FFFFF, 8'hFF};
    vt[6] = '{32'h0000_0020, 1, 0, 32'h0000_0100, 2'd1,
              1, 32'h0000_0100, 2'd1,
              0, 32'h0000_0100, 22'h000000, 8'h08};

    // reset state
    resetn = 1'b0;
    idle();
    cyc();
    cyc();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_upd_valid", 32'(bus.upd_valid), 0);
    chk("rst_redirect", 32'(bus.redirect_valid), 0);
    chk("rst_redirect_pc", bus.redirect_pc, 0);
    resetn = 1'b1;
    #1;
    chk("rst_push_ready", 32'(bus.push_ready), 1);

    // vector table: push, resolve, check update
    for (int i = 0; i < 7; i++) begin
      idle();
      set_push(vt[i].pc, vt[i].hit, vt[i].dir,
               vt[i].tar, vt[i].typ);
      cyc();
      idle();
      chk($sformatf("v%0d_count1", i), 32'(bus.count), 1);
      set_res(vt[i].rdir, vt[i].rtar, vt[i].rtyp);
      cyc();
      idle();
      chk($sformatf("v%0d_upd_valid", i),
          32'(bus.upd_valid), 1);
      chk($sformatf("v%0d_pred_ok", i),
          32'(bus.upd_pred_ok), 32'(vt[i].ok));
      chk($sformatf("v%0d_tag", i),
          32'(bus.upd_tag), 32'(vt[i].tag));
      chk($sformatf("v%0d_index", i),
          32'(bus.upd_index), 32'(vt[i].idx));
      chk($sformatf("v%0d_upd_dir", i),
          32'(bus.upd_dir), 32'(vt[i].rdir));
      chk($sformatf("v%0d_upd_tar", i),
          bus.upd_tar, vt[i].rtar);
      chk($sformatf("v%0d_upd_type", i),
          32'(bus.upd_type), 32'(vt[i].rtyp));
      chk($sformatf("v%0d_redirect", i),
          32'(bus.redirect_valid), 32'(!vt[i].ok));
      chk($sformatf("v%0d_redirect_pc", i),
          bus.redirect_pc, vt[i].rpc);
      chk($sformatf("v%0d_push_ready", i),
          32'(bus.push_ready), 32'(vt[i].ok));
      cyc();
      chk($sformatf("v%0d_pulse_end", i),
          32'(bus.upd_valid), 0);
      chk($sformatf("v%0d_redir_end", i),
          32'(bus.redirect_valid), 0);
      chk($sformatf("v%0d_count0", i), 32'(bus.count), 0);
    end

    // resolve on empty queue is ignored
    idle();
    set_res(1'b1, 32'h1234_0000, 2'd1);
    cyc();
    idle();
    chk("empty_upd_valid", 32'(bus.upd_valid), 0);
    chk("empty_count", 32'(bus.count), 0);

    // fill to full, refuse, then wrap in FIFO order
    do_reset();
    model.delete();
    for (int n = 0; n < 8; n++) begin
      idle();
      set_push(32'h2000 + 32'(n) * 4, 1'b1, 1'b0,
               32'h0, 2'd0);
      model.push_back(32'h2000 + 32'(n) * 4);
      cyc();
    end
    idle();
    chk("full_count", 32'(bus.count), 8);
    chk("full_ready", 32'(bus.push_ready), 0);
    set_push(32'h2FF0, 1'b1, 1'b0, 32'h0, 2'd0);
    cyc();
    chk("full_refuse_count", 32'(bus.count), 8);
    set_res(1'b0, 32'h0, 2'd0);
    #1;
    chk("full_res_ready", 32'(bus.push_ready), 0);
    cyc();
    idle();
    exp_pc = model.pop_front();
    chk("full_res_count", 32'(bus.count), 7);
    chk("full_res_index", 32'(bus.upd_index),
        32'(exp_pc[9:2]));
    for (int k = 0; k < 12; k++) begin
      idle();
      if (k % 2 == 0) begin
        set_res(1'b0, 32'h0, 2'd0);
        cyc();
        exp_pc = model.pop_front();
        chk($sformatf("wrap%0d_ok", k),
            32'(bus.upd_valid && bus.upd_pred_ok), 1);
        chk($sformatf("wrap%0d_index", k),
            32'(bus.upd_index), 32'(exp_pc[9:2]));
      end else begin
        set_push(32'h2020 + 32'(k) * 4, 1'b1, 1'b0,
                 32'h0, 2'd0);
        model.push_back(32'h2020 + 32'(k) * 4);
        cyc();
      end
    end
    idle();
    chk("wrap_count", 32'(bus.count), 7);
    for (int d = 0; d < 7; d++) begin
      idle();
      set_res(1'b0, 32'h0, 2'd0);
      cyc();
      exp_pc = model.pop_front();
      chk($sformatf("drain%0d_index", d),
          32'(bus.upd_index), 32'(exp_pc[9:2]));
    end
    idle();
    chk("drain_count", 32'(bus.count), 0);

    // flush: oldest mispredicts with a push in flight
    do_reset();
    for (int n = 0; n < 5; n++) begin
      idle();
      set_push(32'h3000 + 32'(n) * 4, 1'b1, 1'b1,
               32'h4000, 2'd0);
      cyc();
    end
    idle();
    chk("flush_pre_count", 32'(bus.count), 5);
    set_push(32'h5020, 1'b1, 1'b0, 32'h0, 2'd0);
    set_res(1'b0, 32'h0, 2'd0);
    cyc();
    idle();
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_redirect", 32'(bus.redirect_valid), 1);
    chk("flush_redirect_pc", bus.redirect_pc, 32'h3008);
    chk("flush_ready0", 32'(bus.push_ready), 0);
    cyc();
    chk("flush_ready1", 32'(bus.push_ready), 1);
    chk("flush_redir_end", 32'(bus.redirect_valid), 0);
    set_push(32'h6010, 1'b1, 1'b0, 32'h0, 2'd0);
    cyc();
    idle();
    chk("flush_dropped_count", 32'(bus.count), 1);
    set_res(1'b0, 32'h0, 2'd0);
    cyc();
    idle();
    chk("flush_next_index", 32'(bus.upd_index), 32'h04);

    // reset mid-operation beats a mispredicting resolve
    for (int n = 0; n < 3; n++) begin
      idle();
      set_push(32'h7000 + 32'(n) * 4, 1'b1, 1'b1,
               32'h7100, 2'd0);
      cyc();
    end
    idle();
    chk("midrst_pre_count", 32'(bus.count), 3);
    set_res(1'b0, 32'h0, 2'd0);
    resetn = 1'b0;
    cyc();
    idle();
    chk("midrst_count", 32'(bus.count), 0);
    chk("midrst_redirect", 32'(bus.redirect_valid), 0);
    chk("midrst_upd_valid", 32'(bus.upd_valid), 0);
    resetn = 1'b1;
    #1;
    chk("midrst_ready", 32'(bus.push_ready), 1);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
